// File: rtl/pixel_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pixel_stream_pkg
// Description : Shared types and constants for the RGB24 pixel stream stages.
// Revision    : 1.0 - initial release
// ============================================================================
package pixel_stream_pkg;

    // One RGB pixel; packing order puts b in byte 0
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb24_t;

    localparam int         PHASES    = 4;
    localparam int         PHASE_W   = $clog2(PHASES);
    localparam logic [3:0] KEEP_FULL = 4'hF;
    localparam logic [3:0] KEEP_3B   = 4'h7;
    localparam logic [3:0] KEEP_2B   = 4'h3;
    localparam logic [3:0] KEEP_1B   = 4'h1;

    // RUN: normal packing, TAIL: second flush word waiting for the output register
    typedef enum logic [0:0] {
        RUN  = 1'b0,
        TAIL = 1'b1
    } pack_state_e;

    function automatic rgb24_t make_pixel(input logic [7:0] red,
                                          input logic [7:0] green,
                                          input logic [7:0] blue);
        rgb24_t px;
        px.r = red;
        px.g = green;
        px.b = blue;
        return px;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_out_reg.sv
`default_nettype none
// ============================================================================
// Module      : axis_out_reg
// Description : Single-entry AXI4-Stream output register. Accepts a new word
//               whenever it is empty or its current word is being taken.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_out_reg #(
    parameter int DATA_W = 32,
    parameter int KEEP_W = DATA_W / 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [KEEP_W-1:0] keep_i,
    input  logic              last_i,
    input  logic              user_i,
    output logic              ready_o,
    output logic [DATA_W-1:0] tdata_o,
    output logic [KEEP_W-1:0] tkeep_o,
    output logic              tlast_o,
    output logic              tuser_o,
    output logic              tvalid_o,
    input  logic              tready_i
);

    logic [DATA_W-1:0] tdata_q;
    logic [KEEP_W-1:0] tkeep_q;
    logic              tlast_q;
    logic              tuser_q;
    logic              tvalid_q;

    assign ready_o  = !tvalid_q || tready_i;
    assign tdata_o  = tdata_q;
    assign tkeep_o  = tkeep_q;
    assign tlast_o  = tlast_q;
    assign tuser_o  = tuser_q;
    assign tvalid_o = tvalid_q;

    // Load a new word when there is room, otherwise drop valid once the sink takes it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tlast_q  <= 1'b0;
            tuser_q  <= 1'b0;
            tvalid_q <= 1'b0;
        end else if (load_i && ready_o) begin
            tdata_q  <= data_i;
            tkeep_q  <= keep_i;
            tlast_q  <= last_i;
            tuser_q  <= user_i;
            tvalid_q <= 1'b1;
        end else if (tready_i) begin
            tvalid_q <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rgb24_axis_packer.sv
`default_nettype none
// ============================================================================
// Module      : rgb24_axis_packer
// Description : Packs 24-bit RGB pixels densely into 32-bit AXI4-Stream words
//               (4 pixels -> 3 words), flushing partial words at end of line.
//               Optional macro PACKER_FRAME_CNT_EN adds frame_count,
//               err_resync and line_len_err outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module rgb24_axis_packer
    import pixel_stream_pkg::*;
#(
    parameter int LINE_PIXELS = 640,
    parameter int FRAME_CNT_W = 16
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [7:0]  r,
    input  logic [7:0]  g,
    input  logic [7:0]  b,
    input  logic        valid,
    output logic        in_stream_ready,
    input  logic        sof,
    input  logic        eol,
    output logic [31:0] out_stream_tdata,
    output logic [3:0]  out_stream_tkeep,
    output logic        out_stream_tlast,
    output logic        out_stream_tuser,
    output logic        out_stream_tvalid,
    input  logic        out_stream_tready
`ifdef PACKER_FRAME_CNT_EN
    ,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic                   err_resync,
    output logic                   line_len_err
`endif
);

    pack_state_e        state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [23:0]        residue_q, residue_d;
    logic               pending_sof_q, pending_sof_d;
    logic [3:0]         tail_keep_q, tail_keep_d;

    rgb24_t             w_pix;
    logic               w_accept;
    logic               w_out_ready;
    logic               w_load;
    logic [31:0]        w_word;
    logic [3:0]         w_keep;
    logic               w_last;
    logic               w_user;
    logic [PHASE_W-1:0] w_eff_phase;

    assign w_pix           = make_pixel(r, g, b);
    assign in_stream_ready = (state_q == RUN) && w_out_ready;
    assign w_accept        = valid && in_stream_ready;
    // A sof pixel always restarts packing as the first pixel of a group
    assign w_eff_phase     = sof ? '0 : phase_q;

    // Packing state register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= RUN;
            phase_q       <= '0;
            residue_q     <= '0;
            pending_sof_q <= 1'b0;
            tail_keep_q   <= '0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            residue_q     <= residue_d;
            pending_sof_q <= pending_sof_d;
            tail_keep_q   <= tail_keep_d;
        end
    end

    // Next-state and word assembly; residue keeps unconsumed bytes right-aligned
    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        residue_d     = residue_q;
        pending_sof_d = pending_sof_q;
        tail_keep_d   = tail_keep_q;
        w_load        = 1'b0;
        w_word        = '0;
        w_keep        = '0;
        w_last        = 1'b0;
        w_user        = 1'b0;

        if (state_q == TAIL) begin
            // Residue already holds the zero-padded leftover bytes of the line
            w_load = 1'b1;
            w_word = {8'h00, residue_q};
            w_keep = tail_keep_q;
            w_last = 1'b1;
            if (w_out_ready) begin
                state_d   = RUN;
                residue_d = '0;
            end
        end else if (w_accept) begin
            w_user = pending_sof_q || sof;
            case (w_eff_phase)
                2'd0: begin
                    if (eol) begin
                        w_load    = 1'b1;
                        w_word    = {8'h00, w_pix};
                        w_keep    = KEEP_3B;
                        w_last    = 1'b1;
                        phase_d   = 2'd0;
                        residue_d = '0;
                    end else begin
                        residue_d = w_pix;
                        phase_d   = 2'd1;
                    end
                end
                2'd1: begin
                    w_load    = 1'b1;
                    w_word    = {w_pix[7:0], residue_q};
                    w_keep    = KEEP_FULL;
                    residue_d = {8'h00, w_pix[23:8]};
                    if (eol) begin
                        state_d     = TAIL;
                        tail_keep_d = KEEP_2B;
                        phase_d     = 2'd0;
                    end else begin
                        phase_d = 2'd2;
                    end
                end
                2'd2: begin
                    w_load    = 1'b1;
                    w_word    = {w_pix[15:0], residue_q[15:0]};
                    w_keep    = KEEP_FULL;
                    residue_d = {16'h0000, w_pix[23:16]};
                    if (eol) begin
                        state_d     = TAIL;
                        tail_keep_d = KEEP_1B;
                        phase_d     = 2'd0;
                    end else begin
                        phase_d = 2'd3;
                    end
                end
                default: begin
                    w_load    = 1'b1;
                    w_word    = {w_pix, residue_q[7:0]};
                    w_keep    = KEEP_FULL;
                    w_last    = eol;
                    residue_d = '0;
                    phase_d   = 2'd0;
                end
            endcase
            pending_sof_d = w_user && !w_load;
        end
    end

    axis_out_reg #(
        .DATA_W (32),
        .KEEP_W (4)
    ) u_out_reg (
        .clk_i    (aclk),
        .rst_ni   (aresetn),
        .load_i   (w_load),
        .data_i   (w_word),
        .keep_i   (w_keep),
        .last_i   (w_last),
        .user_i   (w_user),
        .ready_o  (w_out_ready),
        .tdata_o  (out_stream_tdata),
        .tkeep_o  (out_stream_tkeep),
        .tlast_o  (out_stream_tlast),
        .tuser_o  (out_stream_tuser),
        .tvalid_o (out_stream_tvalid),
        .tready_i (out_stream_tready)
    );

`ifdef PACKER_FRAME_CNT_EN
    localparam int IDX_W = $clog2(LINE_PIXELS) + 1;

    logic [FRAME_CNT_W-1:0] frame_cnt_q;
    logic                   err_resync_q;
    logic                   line_len_err_q;
    logic [IDX_W-1:0]       pix_idx_q;
    logic [IDX_W-1:0]       w_line_idx;

    assign w_line_idx   = sof ? '0 : pix_idx_q;
    assign frame_count  = frame_cnt_q;
    assign err_resync   = err_resync_q;
    assign line_len_err = line_len_err_q;

    // Frame statistics: frames seen downstream, resyncs and wrong line lengths
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            frame_cnt_q    <= '0;
            err_resync_q   <= 1'b0;
            line_len_err_q <= 1'b0;
            pix_idx_q      <= '0;
        end else begin
            if (out_stream_tvalid && out_stream_tready && out_stream_tuser) begin
                frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
            end
            if (w_accept) begin
                if (sof && (phase_q != '0)) begin
                    err_resync_q <= 1'b1;
                end
                if (eol) begin
                    if (w_line_idx != IDX_W'(LINE_PIXELS - 1)) begin
                        line_len_err_q <= 1'b1;
                    end
                    pix_idx_q <= '0;
                end else if (w_line_idx != '1) begin
                    pix_idx_q <= w_line_idx + IDX_W'(1);
                end else begin
                    pix_idx_q <= w_line_idx;
                end
            end
        end
    end
`else
    // Statistics parameters only matter when the statistics outputs exist
    logic [31:0] w_cfg_unused;
    assign w_cfg_unused = 32'(LINE_PIXELS) ^ 32'(FRAME_CNT_W);
`endif

endmodule
`default_nettype wire

// File: tb/tb_rgb24_axis_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rgb24_axis_packer
// Description : Self-checking bench for rgb24_axis_packer using a byte-queue
//               reference model and randomized stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rgb24_axis_packer;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [7:0]  r = '0, g = '0, b = '0;
    logic        valid = 1'b0;
    logic        in_stream_ready;
    logic        sof = 1'b0, eol = 1'b0;
    logic [31:0] out_stream_tdata;
    logic [3:0]  out_stream_tkeep;
    logic        out_stream_tlast, out_stream_tuser, out_stream_tvalid;
    logic        out_stream_tready = 1'b1;
`ifdef PACKER_FRAME_CNT_EN
    logic [15:0] frame_count;
    logic        err_resync, line_len_err;
`endif

    rgb24_axis_packer #(.LINE_PIXELS(640), .FRAME_CNT_W(16)) dut (
        .aclk(aclk), .aresetn(aresetn), .r(r), .g(g), .b(b), .valid(valid),
        .in_stream_ready(in_stream_ready), .sof(sof), .eol(eol),
        .out_stream_tdata(out_stream_tdata), .out_stream_tkeep(out_stream_tkeep),
        .out_stream_tlast(out_stream_tlast), .out_stream_tuser(out_stream_tuser),
        .out_stream_tvalid(out_stream_tvalid), .out_stream_tready(out_stream_tready)
`ifdef PACKER_FRAME_CNT_EN
        , .frame_count(frame_count), .err_resync(err_resync), .line_len_err(line_len_err)
`endif
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
        logic        u;
    } word_t;

    int    checks = 0;
    int    failures = 0;
    int    rdy_mode = 0;     // 0: always ready, 1: random, 2: held low
    int    gap_pct = 0;
    int    ready_low_cnt = 0;
    int    word_cnt = 0;
    int    last_cnt = 0;
    int    user_acc = 0;

    logic [7:0] m_bytes[$];
    logic       m_pending = 1'b0;
    word_t      exp_q[$];
    word_t      model_log[$];
    word_t      obs_log[$];

    logic       prev_stall = 1'b0;
    word_t      prev_w;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    // Reference: bytes of the line accumulate little-endian; every 4 form a
    // word, eol flushes the remainder, sof discards an unfinished group.
    function automatic void model_push(input logic [23:0] p, input logic s, input logic e);
        word_t loc[$];
        word_t w;
        int    n;
        if (s) begin
            m_bytes.delete();
            m_pending = 1'b1;
        end
        m_bytes.push_back(p[7:0]);
        m_bytes.push_back(p[15:8]);
        m_bytes.push_back(p[23:16]);
        while (m_bytes.size() >= 4) begin
            w = '0;
            for (int i = 0; i < 4; i++) w.d[8*i +: 8] = m_bytes.pop_front();
            w.k = 4'hF;
            loc.push_back(w);
        end
        if (e && m_bytes.size() > 0) begin
            w = '0;
            n = m_bytes.size();
            for (int i = 0; i < n; i++) begin
                w.d[8*i +: 8] = m_bytes.pop_front();
                w.k[i] = 1'b1;
            end
            loc.push_back(w);
        end
        if (e && loc.size() > 0) begin
            w = loc.pop_back();
            w.l = 1'b1;
            loc.push_back(w);
        end
        foreach (loc[i]) begin
            w = loc[i];
            if (m_pending) begin
                w.u = 1'b1;
                m_pending = 1'b0;
            end
            exp_q.push_back(w);
            model_log.push_back(w);
        end
    endfunction

    // Compare process: ready rule, hold stability and every accepted word
    always @(negedge aclk) begin
        word_t cur, e;
        cur = {out_stream_tdata, out_stream_tkeep, out_stream_tlast, out_stream_tuser};
        if (!aresetn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", {63'd0, out_stream_tvalid}, 64'd1);
                chk("hold_word", {26'd0, cur}, {26'd0, prev_w});
            end
            if (!out_stream_tvalid)
                chk("ready_when_empty", {63'd0, in_stream_ready}, 64'd1);
            else if (!out_stream_tready)
                chk("ready_when_stalled", {63'd0, in_stream_ready}, 64'd0);
            if (!in_stream_ready) ready_low_cnt++;
            if (valid && in_stream_ready) model_push({r, g, b}, sof, eol);
            if (out_stream_tvalid && out_stream_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", {32'd0, out_stream_tdata}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_word", {26'd0, cur}, {26'd0, e});
                end
                obs_log.push_back(cur);
                word_cnt++;
                if (out_stream_tlast) last_cnt++;
                if (out_stream_tuser) user_acc++;
            end
            prev_stall = out_stream_tvalid && !out_stream_tready;
            prev_w = cur;
        end
    end

    // Sink back-pressure
    initial begin
        forever begin
            @(posedge aclk);
            #1;
            case (rdy_mode)
                0:       out_stream_tready = 1'b1;
                1:       out_stream_tready = ($urandom_range(0, 3) != 0);
                default: out_stream_tready = 1'b0;
            endcase
        end
    end

    // Offer one pixel and hold it until accepted; called just after a rising edge
    task automatic send_px(input logic [23:0] p, input logic s, input logic e);
        int guard;
        guard = 0;
        if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
            @(posedge aclk);
            #1;
        end
        {r, g, b} = p;
        sof = s;
        eol = e;
        valid = 1'b1;
        @(negedge aclk);
        while (!in_stream_ready && guard < 200) begin
            guard++;
            @(negedge aclk);
        end
        if (guard >= 200) chk("send_timeout", 64'd1, 64'd0);
        @(posedge aclk);
        #1;
        valid = 1'b0;
        sof = 1'b0;
        eol = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        @(negedge aclk);
        while ((exp_q.size() != 0 || out_stream_tvalid) && guard < 500) begin
            guard++;
            @(negedge aclk);
        end
        if (guard >= 500) chk("drain_timeout", 64'd1, 64'd0);
        @(posedge aclk);
        #1;
    endtask

    task automatic reset_window();
        ready_low_cnt = 0;
        word_cnt = 0;
        last_cnt = 0;
    endtask

    int          base;
    int          len;
    logic        s_bit;
    logic [23:0] px;

    initial begin
        // ---------------- reset state ----------------
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_tvalid", {63'd0, out_stream_tvalid}, 64'd0);
        chk("rst_tdata", {32'd0, out_stream_tdata}, 64'd0);
        chk("rst_tkeep_tlast_tuser", {58'd0, out_stream_tkeep, out_stream_tlast, out_stream_tuser}, 64'd0);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("rst_in_ready", {63'd0, in_stream_ready}, 64'd1);
`ifdef PACKER_FRAME_CNT_EN
        chk("rst_err_resync", {63'd0, err_resync}, 64'd0);
        chk("rst_frame_count", {48'd0, frame_count}, 64'd0);
`endif
        @(posedge aclk);
        #1;

        // ---------------- four-pixel group ----------------
        reset_window();
        base = obs_log.size();
        send_px(24'h112233, 1'b1, 1'b0);
        send_px(24'h556644, 1'b0, 1'b0);
        send_px(24'h997788, 1'b0, 1'b0);
        send_px(24'hAABBCC, 1'b0, 1'b0);
        drain();
        chk("grp_words", word_cnt, 3);
        chk("grp_ready_low", ready_low_cnt, 0);
        if (obs_log.size() >= base + 3) begin
            chk("grp_w0", {26'd0, obs_log[base]},   {26'd0, 32'h44112233, 4'hF, 1'b0, 1'b1});
            chk("grp_w1", {26'd0, obs_log[base+1]}, {26'd0, 32'h77885566, 4'hF, 1'b0, 1'b0});
            chk("grp_w2", {26'd0, obs_log[base+2]}, {26'd0, 32'hAABBCC99, 4'hF, 1'b0, 1'b0});
            chk("model_w0", {26'd0, model_log[base]}, {26'd0, 32'h44112233, 4'hF, 1'b0, 1'b1});
            chk("model_w2", {26'd0, model_log[base+2]}, {26'd0, 32'hAABBCC99, 4'hF, 1'b0, 1'b0});
        end

        // ---------------- full 640-pixel line ----------------
        reset_window();
        for (int i = 0; i < 640; i++) begin
            px = 24'($urandom);
            send_px(px, i == 0, i == 639);
        end
        drain();
        chk("line640_words", word_cnt, 480);
        chk("line640_tlast", last_cnt, 1);
        chk("line640_ready_low", ready_low_cnt, 0);
        chk("line640_last_on_final", {63'd0, obs_log[obs_log.size()-1].l}, 64'd1);
`ifdef PACKER_FRAME_CNT_EN
        chk("line640_len_ok", {63'd0, line_len_err}, 64'd0);
`endif

        // ---------------- mid-line stall ----------------
        reset_window();
        fork
            begin
                for (int i = 0; i < 12; i++) send_px(24'($urandom), 1'b0, 1'b0);
            end
            begin
                repeat (4) @(posedge aclk);
                rdy_mode = 2;
                repeat (5) @(posedge aclk);
                rdy_mode = 0;
            end
        join
        drain();
        chk("stall_words", word_cnt, 9);

        // ---------------- six-pixel line: tail word ----------------
        reset_window();
        base = obs_log.size();
        send_px(24'h010101, 1'b1, 1'b0);
        send_px(24'h020202, 1'b0, 1'b0);
        send_px(24'h030303, 1'b0, 1'b0);
        send_px(24'h040404, 1'b0, 1'b0);
        send_px(24'h123456, 1'b0, 1'b0);
        send_px(24'hABCDEF, 1'b0, 1'b1);
        drain();
        chk("tail_words", word_cnt, 5);
        chk("tail_ready_low", ready_low_cnt, 1);
        if (obs_log.size() >= base + 5) begin
            chk("tail_w3", {26'd0, obs_log[base+3]}, {26'd0, 32'hEF123456, 4'hF, 1'b0, 1'b0});
            chk("tail_w4", {26'd0, obs_log[base+4]}, {26'd0, 32'h0000ABCD, 4'h3, 1'b1, 1'b0});
        end

        // ---------------- single-pixel line with sof and eol ----------------
        base = obs_log.size();
        send_px(24'h0A0B0C, 1'b1, 1'b1);
        drain();
        if (obs_log.size() >= base + 1)
            chk("one_px", {26'd0, obs_log[base]}, {26'd0, 32'h000A0B0C, 4'h7, 1'b1, 1'b1});

        // ---------------- sof at phase 2: resync ----------------
        base = obs_log.size();
        send_px(24'hEEEEEE, 1'b0, 1'b0);
        send_px(24'hDDDDDD, 1'b0, 1'b0);
        send_px(24'h010203, 1'b1, 1'b0);
        send_px(24'h040506, 1'b0, 1'b0);
        send_px(24'h070809, 1'b0, 1'b0);
        send_px(24'h0A0B0C, 1'b0, 1'b1);
        drain();
        if (obs_log.size() >= base + 2)
            chk("resync_w0", {26'd0, obs_log[base+1]}, {26'd0, 32'h06010203, 4'hF, 1'b0, 1'b1});
`ifdef PACKER_FRAME_CNT_EN
        chk("resync_flag", {63'd0, err_resync}, 64'd1);
`endif

        // ---------------- async reset while stalled ----------------
        rdy_mode = 2;
        repeat (2) @(posedge aclk);
        #1;
        send_px(24'h333333, 1'b1, 1'b0);
        send_px(24'h444444, 1'b0, 1'b0);
        @(negedge aclk);
        chk("pre_reset_tvalid", {63'd0, out_stream_tvalid}, 64'd1);
        #2;
        aresetn = 1'b0;
        #1;
        chk("async_reset_tvalid", {63'd0, out_stream_tvalid}, 64'd0);
        m_bytes.delete();
        exp_q.delete();
        m_pending = 1'b0;
        user_acc = 0;
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        rdy_mode = 0;
`ifdef PACKER_FRAME_CNT_EN
        chk("post_reset_err_resync", {63'd0, err_resync}, 64'd0);
`endif
        base = obs_log.size();
        send_px(24'hC0FFEE, 1'b1, 1'b0);
        send_px(24'h123456, 1'b0, 1'b0);
        send_px(24'h654321, 1'b0, 1'b0);
        send_px(24'h777777, 1'b0, 1'b1);
        drain();
        if (obs_log.size() >= base + 1)
            chk("post_reset_w0", {26'd0, obs_log[base]}, {26'd0, 32'h56C0FFEE, 4'hF, 1'b0, 1'b1});

        // ---------------- randomized lines ----------------
        gap_pct = 20;
        rdy_mode = 1;
        for (int ln = 0; ln < 40; ln++) begin
            len = $urandom_range(1, 13);
            for (int i = 0; i < len; i++) begin
                s_bit = ((i == 0) && (ln % 4 == 0)) || ($urandom_range(0, 19) == 0);
                px = 24'($urandom);
                send_px(px, s_bit, i == len - 1);
            end
        end
        rdy_mode = 0;
        gap_pct = 0;
        drain();
        chk("scoreboard_empty", exp_q.size(), 0);
`ifdef PACKER_FRAME_CNT_EN
        chk("frame_count", {48'd0, frame_count}, {48'd0, 16'(user_acc)});
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/rgb24_axis_packer.md
Name: rgb24_axis_packer

Overview:
- Downstream neighbour of the pixel generator.
- Accepts one 24-bit RGB pixel per handshake, with start-of-frame and end-of-line markers.
- Packs pixels densely into 32-bit AXI4-Stream words for the video DMA: 4 pixels become 3 words.
- A single output register decouples the generator's stalls from DMA back-pressure.

Parameters:
- LINE_PIXELS, 640, nominal pixels per line; used only by the optional statistics feature.
- FRAME_CNT_W, 16, width of the optional frame counter.

Ports:
- aclk  in  1  stream clock; all logic on its rising edge.
- aresetn  in  1  asynchronous active-low reset.
- r  in  8  pixel red.
- g  in  8  pixel green.
- b  in  8  pixel blue.
- valid  in  1  pixel offered.
- in_stream_ready  out  1  pixel accepted when valid && in_stream_ready.
- sof  in  1  pixel is first of frame; qualified by the handshake.
- eol  in  1  pixel is last of line; qualified by the handshake.
- out_stream_tdata  out  32  packed word.
- out_stream_tkeep  out  4  byte enables.
- out_stream_tlast  out  1  word ends a line.
- out_stream_tuser  out  1  word begins a frame.
- out_stream_tvalid  out  1  word valid.
- out_stream_tready  in  1  sink ready.

Behaviour:
- Reset (async assert, sync release): out_stream_tvalid=0, tdata=0, tkeep=0, tlast=0, tuser=0, phase=0, residue=0, pending_sof=0.
  - in_stream_ready after reset release is 1.
  - Reset mid-line discards residue and any pending word.
- Pixel value P = {r,g,b}; byte 0 of P is b.
- Stream is P0,P1,P2,P3 little-endian:
  - word0 = {P1[7:0], P0}
  - word1 = {P2[15:0], P1[23:8]}
  - word2 = {P3, P2[23:16]}
- phase is a 2-bit counter, advancing mod 4 per accepted pixel.
  - phase 0 stores P into residue and emits nothing.
  - phases 1, 2 and 3 each emit one word and update residue.
  - phase 3 leaves residue empty.
- in_stream_ready = !out_stream_tvalid || out_stream_tready. Phase 0 uses the same rule.
- Output register:
  - Loads on an accepted pixel that emits.
  - Clears tvalid on tready when no new word is loaded.
  - tdata, tkeep, tlast and tuser are held stable while tvalid && !tready.
- Latency: the word is visible the cycle after the accepting edge.
- Throughput: 1 pixel/cycle under continuous tready, giving 3 words per 4 cycles.
- tkeep=4'hF on all full words.
- tuser:
  - sof on an accepted pixel sets pending_sof.
  - The next emitted word carries tuser=1, then pending_sof clears.
  - sof accepted at phase 0 therefore marks word0.
- tlast: eol at phase 3 sets tlast on word2 and phase returns to 0.
- eol at phase != 3 forces a flush word in the same emission, with tlast=1 and phase reset to 0:
  - at phase 0: word {8'h0, P}, tkeep=4'h7.
  - at phase 1: normal word0 plus residue lost? No — a 2-word flush is not allowed. Instead, line lengths not divisible by 4 emit a tail word with tkeep covering valid bytes, and in_stream_ready deasserts for one extra cycle while the second word drains.
    - phase 1 eol: word0 (tkeep F), then {16'h0, P1[23:8]} with tkeep=4'h3 and tlast.
    - phase 2 eol: word1 (tkeep F), then {24'h0, P2[23:16]} with tkeep=4'h1 and tlast.
- State machine: RUN, TAIL.
  - TAIL holds the second flush word and forces in_stream_ready=0.
  - TAIL returns to RUN once the tail word is accepted.
- sof accepted while phase != 0 (truncated line): residue is dropped, phase restarts as if at phase 0 with this pixel, and sticky error flag err_resync is set. err_resync is internal and exported only under the option.
- Simultaneous sof and eol on one pixel (1-pixel line) is legal: phase-0 eol flush applies, with tuser=1 and tlast=1.

Optional Feature:
- Macro PACKER_FRAME_CNT_EN. When defined, adds:
  - output frame_count [FRAME_CNT_W-1:0]: increments on each tuser word accepted downstream, wraps to 0.
  - output err_resync [1] (sticky, cleared by reset).
  - output line_len_err [1]: sticky, set when an eol pixel index != LINE_PIXELS-1.
- When undefined, these ports and counters do not exist; the datapath is identical.

Decomposition:
- Shared package pixel_stream_pkg holds:
  - typedef rgb24_t;
  - localparams PHASES=4, KEEP_FULL=4'hF, KEEP_3B=4'h7, KEEP_2B=4'h3, KEEP_1B=4'h1;
  - state enum {RUN, TAIL}.
- One natural sub-module, axis_out_reg: a single-entry output register with the ready/valid rule above, reusable by other stream stages.

Test Plan:
- Reset, then 4 pixels P0=0x112233..P3=0xAABBCC with sof on P0 and tready=1 -> words 0x33112233? No, exactly:
  - 0x44112233, 0x77885566, 0xAABBCC99;
  - tuser on word 1 only; tkeep=F; in_stream_ready continuously 1.
- 640-pixel line with eol on the last pixel -> 480 words; tlast only on word 480; no TAIL entry.
- tready=0 for 5 cycles mid-line -> tdata stable throughout, in_stream_ready=0, no pixel lost or duplicated; 12 pixels yield 9 words.
- 6-pixel line (eol at phase 1) -> word0 tkeep F, then tail word {16'h0, P5[23:8]} with tkeep=3 and tlast; in_stream_ready low for exactly the TAIL cycle.
- sof at phase 2 -> residue dropped, next word0 built from the new P0, err_resync=1 (with PACKER_FRAME_CNT_EN).
- aresetn pulled low while tvalid=1 and tready=0 -> tvalid falls immediately (async); first post-reset word is the correct word0 of new pixels.
